// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the read and write sides of the handshake FIFO.
//
// Contents:
//   fifo_state_e - handshake controller states (IDLE, FETCH, HOLD, POP)
//   ptr_width    - pointer width for a given RAM address width (one extra wrap bit)
//   ptr_empty    - pointer compare that signals an empty buffer
//   ptr_full     - pointer compare that signals a full buffer
//
// The compare helpers take pointers zero-extended to 32 bits so that both
// sides can use them whatever their DEPTH parameter is.

package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    POP   = 2'd3
  } fifo_state_e;

  // Pointers carry one bit above the RAM address.
  // That bit tells a full buffer apart from an empty one.
  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

  // Empty: every pointer bit matches, including the wrap bit.
  function automatic logic ptr_empty(input logic [31:0] rd_ptr,
                                     input logic [31:0] wr_ptr);
    return (rd_ptr == wr_ptr);
  endfunction

  // Full: the addresses match and the wrap bits differ.
  // In other words, the two pointers differ only in bit addr_w.
  function automatic logic ptr_full(input logic [31:0] wr_ptr,
                                    input logic [31:0] rd_ptr,
                                    input int          addr_w);
    return ((wr_ptr ^ rd_ptr) == (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// fifo_ptr_cnt
// Pointer counter used by the FIFO controllers. It is PTR_W bits wide and
// wraps naturally at 2^PTR_W. The top bit is the wrap bit, so it toggles
// each time the RAM address rolls over.
//
// Ports:
//   clk    in  1      system clock
//   rst    in  1      synchronous active-high reset, clears the pointer
//   inc_en in  1      advance the pointer by one on this edge
//   ptr    out PTR_W  current pointer value

module fifo_ptr_cnt #(
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Next pointer value.
  // Adding one with no carry-out gives the modulo-2^PTR_W wrap we need.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_en) begin
      ptr_d = ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end
  end

  // Pointer register.
  // Reset has priority over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl
// Read side of the handshake FIFO. This block:
//   - owns the read pointer,
//   - derives empty from the write pointer,
//   - fetches one word from the synchronous-read buffer RAM,
//   - holds that word for the consumer until the consumer releases r_en.
//
// Ports:
//   clk          in  1         system clock
//   rst          in  1         synchronous active-high reset
//   r_en         in  1         consumer read request, held until data is taken
//   wr_ptr       in  ADDR_W+1  write pointer from the write side
//   ram_rd_data  in  WIDTH     RAM read data, one cycle after ram_rd_addr
//   ram_rd_addr  out ADDR_W    RAM read address, low bits of rd_ptr
//   rd_ptr       out ADDR_W+1  read pointer, returned to the write side
//   empty        out 1         rd_ptr == wr_ptr
//   valid        out 1         dout holds a fetched word
//   dout         out WIDTH     registered output data
//   level        out ADDR_W+1  occupancy, registered   (FIFO_RD_LEVEL_EN only)
//   almost_empty out 1         level <= 1, registered  (FIFO_RD_LEVEL_EN only)
//
// Build option: define FIFO_RD_LEVEL_EN to add the level and almost_empty
// outputs.

module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_en,
  input  logic [ADDR_W:0]   wr_ptr,
  input  logic [WIDTH-1:0]  ram_rd_data,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic [ADDR_W:0]   rd_ptr,
  output logic              empty,
`ifdef FIFO_RD_LEVEL_EN
  output logic [ADDR_W:0]   level,
  output logic              almost_empty,
`endif
  output logic              valid,
  output logic [WIDTH-1:0]  dout
);

  localparam int PTR_W = ptr_width(ADDR_W);

  fifo_state_e      state_q;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic [PTR_W-1:0] rd_ptr_w;
  logic             empty_w;
  logic             pop_w;

  // The pointer advances only when the word is committed (POP).
  // A word the consumer is still holding therefore cannot be overwritten
  // by the write side.
  assign pop_w = (state_q == POP);

  fifo_ptr_cnt #(
    .PTR_W (PTR_W)
  ) u_rd_ptr (
    .clk    (clk),
    .rst    (rst),
    .inc_en (pop_w),
    .ptr    (rd_ptr_w)
  );

  assign empty_w = ptr_empty(32'(rd_ptr_w), 32'(wr_ptr));

  // Handshake controller and output register.
  // The address is always the current read pointer. By the time a request
  // is accepted, the RAM already has the word in its pipeline. FETCH covers
  // the RAM latency, and the word is captured on the way into HOLD.
  // valid is registered, so no combinational path runs from r_en to any
  // output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (r_en && !empty_w) begin
            state_q <= FETCH;
          end
        end
        FETCH: begin
          dout_q  <= ram_rd_data;
          valid_q <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: begin
          if (!r_en) begin
            valid_q <= 1'b0;
            state_q <= POP;
          end
        end
        POP: begin
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [PTR_W-1:0] level_q;
  logic [PTR_W-1:0] level_d;
  logic             almost_empty_q;
  logic             almost_empty_d;

  // Occupancy from the pointer difference.
  // Modulo arithmetic on the wrap bit keeps the result in 0..DEPTH.
  always_comb begin
    level_d        = wr_ptr - rd_ptr_w;
    almost_empty_d = (level_d <= {{(PTR_W-1){1'b0}}, 1'b1});
  end

  // Registered one cycle behind the pointers.
  // This keeps the level path off the pointer compare timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q        <= '0;
      almost_empty_q <= 1'b1;
    end else begin
      level_q        <= level_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign level        = level_q;
  assign almost_empty = almost_empty_q;
`endif

  assign ram_rd_addr = rd_ptr_w[ADDR_W-1:0];
  assign rd_ptr      = rd_ptr_w;
  assign empty       = empty_w;
  assign valid       = valid_q;
  assign dout        = dout_q;

endmodule
